// File: rtl/dmem_rmw_ctrl.sv
// Data-memory responder: word-wide synchronous RAM with load extension and
// read-modify-write sub-word stores behind valid/ready request/response channels.
module dmem_rmw_ctrl #(
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_t;

    state_t         state;
    logic [AW-1:0]  idx_q;
    logic [1:0]     off_q;
    logic [2:0]     funct3_q;
    logic           we_q;
    logic           err_q;
    logic [31:0]    wdata_q;
    logic [31:0]    word_q;
    logic [31:0]    mem [DEPTH];

    function automatic logic req_error(input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr);
        logic legal;
        logic misaligned;
        logic out_of_range;
        legal        = we ? (f3 inside {3'b000, 3'b001, 3'b010})
                          : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned   = ((f3[1:0] == 2'b01) && addr[0]) ||
                       ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        out_of_range = {2'b00, addr[31:2]} >= DEPTH;
        return !legal || misaligned || out_of_range;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
        logic [31:0] s;
        logic [31:0] r;
        s = w >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{24{s[7]}}, s[7:0]};
            3'b001:  r = {{16{s[15]}}, s[15:0]};
            3'b010:  r = w;
            3'b100:  r = {24'h0, s[7:0]};
            3'b101:  r = {16'h0, s[15:0]};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Only the addressed lanes take new data; a word store replaces everything.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] off, input logic [1:0] size);
        logic [31:0] m;
        m = old;
        case (size)
            2'b00:   m[{off, 3'b000} +: 8]         = wd[7:0];
            2'b01:   m[{off[1], 4'b0000} +: 16]    = wd[15:0];
            default: m = wd;
        endcase
        return m;
    endfunction

    assign req_ready = (state == StIdle);

    // Gated by reset so an aborted store never reaches the RAM.
    always_ff @(posedge clk) begin
        if (!reset && state == StWr) begin
            mem[idx_q] <= merge(word_q, wdata_q, off_q, funct3_q[1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        idx_q    <= req_addr[AW+1:2];
                        off_q    <= req_addr[1:0];
                        funct3_q <= req_funct3;
                        we_q     <= req_we;
                        wdata_q  <= req_wdata;
                        err_q    <= req_error(req_we, req_funct3, req_addr);
                        if (req_error(req_we, req_funct3, req_addr)) begin
                            state <= StResp;
                        end else if (req_we && req_funct3[1:0] == 2'b10) begin
                            state <= StWr;
                        end else begin
                            state <= StRd;
                        end
                    end
                end
                StRd: begin
                    word_q <= mem[idx_q];
                    state  <= we_q ? StWr : StResp;
                end
                StWr: begin
                    state     <= StResp;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b0;
                end
                StResp: begin
                    // Loads and errors publish their response one edge after entering.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_q;
                        rsp_rdata <= (err_q || we_q) ? 32'h0 : load_ext(word_q, off_q, funct3_q);
                    end else if (rsp_ready) begin
                        state     <= StIdle;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Directed bench for dmem_rmw_ctrl: byte-addressed reference model plus per-cycle compare.
module tb_dmem_rmw_ctrl;
    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_rmw_ctrl #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic        chk_en    = 1'b0;
    logic        exp_ready = 1'b1;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_err   = 1'b0;

    logic [7:0]  mem_b [4*DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic model_err(input logic we, input logic [2:0] f3,
                                       input logic [31:0] a);
        logic legal;
        int n;
        n = size_of(f3);
        legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
        return !legal || (a % n != 0) || (a / 4 >= DEPTH);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int n;
        logic [31:0] v;
        n = size_of(f3);
        v = 32'h0;
        for (int i = n - 1; i >= 0; i--) v = (v << 8) | 32'(mem_b[a + i]);
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd);
        for (int i = 0; i < size_of(f3); i++) mem_b[a + i] = wd[8*i +: 8];
    endtask

    // Per-cycle compare against the expectations the driver maintains.
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("rsp_rdata", rsp_rdata, exp_rdata);
                check("rsp_err", 32'(rsp_err), 32'(exp_err));
            end
        end
    end

    // One request through to its response; hold cycles keep rsp_ready low while
    // presenting an (ignored) store on the request channel.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic err, output int lat,
                       output logic [31:0] m_rd);
        logic merr;
        int lat_exp;
        merr    = model_err(we, f3, addr);
        m_rd    = (merr || we) ? 32'h0 : model_load(f3, addr);
        lat_exp = (merr || (we && f3 == 3'b010)) ? 1 : 2;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_ready = 1'b0;
        if (!merr && we) model_store(f3, addr, wd);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == lat_exp) begin
                exp_valid = 1'b1; exp_rdata = m_rd; exp_err = merr;
            end
            if (rsp_valid && lat == 0) lat = k;
            if (k >= lat_exp && lat != 0) break;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
            req_addr = 32'h40; req_wdata = 32'hDEAD_BEEF;
            @(posedge clk); #1;
        end
        @(negedge clk);
        req_valid = 1'b0;
        rd  = rsp_rdata;
        err = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_valid = 1'b0; exp_ready = 1'b1; exp_rdata = 32'h0; exp_err = 1'b0;
    endtask

    task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] model_v,
                       input logic [31:0] want);
        check(name, dut_v, want);
        check({name, "_model"}, model_v, want);
    endtask

    logic [31:0] rd;
    logic [31:0] m_rd;
    logic        err;
    int          lat;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_valid", 32'(rsp_valid), 32'd0);
        check("reset_rdata", rsp_rdata, 32'h0);
        check("reset_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Word store then load, with latency pinned.
        txn(1'b1, 3'b010, 32'h40, 32'h1122_3344, 0, rd, err, lat, m_rd);
        check("sw_lat", 32'(lat), 32'd1);
        check("sw_err", 32'(err), 32'd0);
        txn(1'b0, 3'b010, 32'h40, 32'h0, 0, rd, err, lat, m_rd);
        lit("lw_40", rd, m_rd, 32'h1122_3344);
        check("lw_lat", 32'(lat), 32'd2);

        // Byte store merge.
        txn(1'b1, 3'b000, 32'h42, 32'h0000_00AB, 0, rd, err, lat, m_rd);
        check("sb_lat", 32'(lat), 32'd2);
        txn(1'b0, 3'b010, 32'h40, 32'h0, 0, rd, err, lat, m_rd);
        lit("lw_after_sb", rd, m_rd, 32'h11AB_3344);

        // Halfword store then all extension flavours.
        txn(1'b1, 3'b010, 32'h44, 32'h0, 0, rd, err, lat, m_rd);
        txn(1'b1, 3'b001, 32'h46, 32'h1234_BEEF, 0, rd, err, lat, m_rd);
        check("sh_lat", 32'(lat), 32'd2);
        txn(1'b0, 3'b001, 32'h46, 32'h0, 0, rd, err, lat, m_rd);
        lit("lh_46", rd, m_rd, 32'hFFFF_BEEF);
        txn(1'b0, 3'b101, 32'h46, 32'h0, 0, rd, err, lat, m_rd);
        lit("lhu_46", rd, m_rd, 32'h0000_BEEF);
        txn(1'b0, 3'b000, 32'h47, 32'h0, 0, rd, err, lat, m_rd);
        lit("lb_47", rd, m_rd, 32'hFFFF_FFBE);
        txn(1'b0, 3'b100, 32'h46, 32'h0, 0, rd, err, lat, m_rd);
        lit("lbu_46", rd, m_rd, 32'h0000_00EF);
        txn(1'b0, 3'b010, 32'h44, 32'h0, 0, rd, err, lat, m_rd);
        lit("lw_44", rd, m_rd, 32'hBEEF_0000);

        // Error cases: one-cycle response, no RAM effect.
        txn(1'b0, 3'b010, 32'h41, 32'h0, 0, rd, err, lat, m_rd);
        check("err_lw_misal", 32'(err), 32'd1);
        check("err_lw_lat", 32'(lat), 32'd1);
        txn(1'b1, 3'b001, 32'h43, 32'hFFFF_FFFF, 0, rd, err, lat, m_rd);
        check("err_sh_misal", 32'(err), 32'd1);
        txn(1'b1, 3'b010, 32'(4 * DEPTH), 32'hFFFF_FFFF, 0, rd, err, lat, m_rd);
        check("err_sw_range", 32'(err), 32'd1);
        txn(1'b0, 3'b011, 32'h40, 32'h0, 0, rd, err, lat, m_rd);
        check("err_f3_011", 32'(err), 32'd1);
        check("err_f3_rdata", rd, 32'h0);
        txn(1'b1, 3'b100, 32'h40, 32'hFFFF_FFFF, 0, rd, err, lat, m_rd);
        check("err_store_f3", 32'(err), 32'd1);
        txn(1'b0, 3'b010, 32'h40, 32'h0, 0, rd, err, lat, m_rd);
        lit("lw_after_errs", rd, m_rd, 32'h11AB_3344);

        // Back-pressure: response held for 5 cycles, requests ignored meanwhile.
        txn(1'b0, 3'b010, 32'h40, 32'h0, 5, rd, err, lat, m_rd);
        lit("lw_held", rd, m_rd, 32'h11AB_3344);
        txn(1'b0, 3'b010, 32'h40, 32'h0, 0, rd, err, lat, m_rd);
        lit("lw_after_hold", rd, m_rd, 32'h11AB_3344);

        // Reset during the WR cycle of a byte store aborts the write.
        txn(1'b1, 3'b010, 32'h40, 32'h1122_3344, 0, rd, err, lat, m_rd);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h40; req_wdata = 32'h0000_0055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        exp_ready = 1'b1; exp_valid = 1'b0;
        @(negedge clk);
        check("rst_wr_rdata", rsp_rdata, 32'h0);
        check("rst_wr_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        txn(1'b0, 3'b010, 32'h40, 32'h0, 0, rd, err, lat, m_rd);
        lit("lw_after_abort", rd, m_rd, 32'h1122_3344);

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_rmw_ctrl.md
Name: dmem_rmw_ctrl

Overview:
- Data-memory responder for the core's load/store port; the memory-side end of the lb/lh/lw/lbu/lhu/sb/sh/sw interface.
- Owns a word-wide synchronous-read RAM.
- Does byte-lane extraction and sign/zero extension for loads.
- Does sub-word stores by read-modify-write, so the core no longer handles byte/halfword placement.
- Valid/ready request and response channels let the block replace dmem in a multicycle/pipelined core.

Parameters:
DEPTH, 256, number of 32-bit words in the RAM; valid byte addresses 0 .. 4*DEPTH-1.

Ports:
clk        input   1   clock, all state updates on rising edge
reset      input   1   synchronous, active-high
req_valid  input   1   request present
req_ready  output  1   block can accept a request
req_we     input   1   1 = store, 0 = load
req_funct3 input   3   RISC-V funct3 of the load/store
req_addr   input   32  byte address
req_wdata  input   32  store data; low byte/half/word used per funct3
rsp_valid  output  1   response present
rsp_ready  input   1   core accepts response
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err    output  1   misaligned, out-of-range or illegal funct3

Behaviour:
- Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. RAM contents are not cleared.
- Reset mid-operation: abort. A write not yet performed in the current cycle never occurs.
- States: IDLE, RD, WR, RESP.
- Accept: a request is taken at an edge where req_valid & req_ready. req_ready = (state==IDLE). Address, funct3, we and wdata are latched on accept.
- Error check at accept. Error if any of:
  - funct3 illegal: loads allow 000,001,010,100,101; stores allow 000,001,010.
  - halfword access with addr[0]=1.
  - word access with addr[1:0]!=0.
  - addr[31:2] >= DEPTH.
- On error: go straight to RESP with rsp_err=1 and rsp_rdata=0. No RAM access.
- Load: IDLE -> RD -> RESP.
  - RD: RAM word read at addr[31:2], registered at the RD edge.
  - RESP: rsp_rdata = (word >> 8*addr[1:0]), then sign-extended (000, 001) or zero-extended (100, 101) from bit 7 or 15. funct3 010 returns the full word.
  - Accept at edge N gives rsp_valid high from edge N+2.
- Store word: IDLE -> WR -> RESP. RAM written at the WR edge (N+1); rsp_valid from N+1.
- Store byte/half: IDLE -> RD -> WR -> RESP.
  - RD reads the old word.
  - WR writes the merged word: only lanes addr[1:0] (sb) or addr[1]*2 .. +1 (sh) are replaced, with wdata[7:0] or wdata[15:0]. Other lanes are unchanged.
  - rsp_valid from N+2.
- Little-endian lanes: byte at addr[1:0]=0 is bits 7:0.
- RESP: outputs held stable while rsp_valid & !rsp_ready. On an edge with rsp_ready=1, go to IDLE and drop rsp_valid. No request is accepted in that same cycle; the next accept is at the earliest edge after.
- Store responses: rsp_rdata=0, rsp_err=0.
- Only one request is in flight; no buffering or reordering.
- req_* inputs are ignored outside IDLE.

Test Plan:
- sw 0x11223344 @0x40, then lw @0x40 -> lw rsp_rdata=0x11223344, rsp_err=0; rsp_valid exactly 2 cycles after the lw accept.
- Preload 0x11223344 @0x40; sb wdata=0xAB @0x42; lw @0x40 -> 0x11AB3344.
- sh wdata=0xBEEF @0x46 over 0x00000000, then:
  - lh @0x46 -> 0xFFFFBEEF
  - lhu @0x46 -> 0x0000BEEF
  - lb @0x47 -> 0xFFFFFFBE
  - lbu @0x46 -> 0x000000EF
- Errors, each -> rsp_err=1, rsp_valid one cycle after accept, RAM word unchanged:
  - lw @0x41
  - sh @0x43
  - sw @4*DEPTH
  - load with funct3=011
- Hold rsp_ready=0 for 5 cycles after a lw response -> rsp_valid, rsp_rdata stable and req_ready=0 throughout; raising rsp_ready returns to IDLE next edge.
- Assert reset in WR of an sb to 0x40 holding 0x11223344 -> outputs at reset values next cycle; later lw @0x40 returns 0x11223344.
